hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_hazard_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch flush,
// and data-memory wait handling with a bounded timeout.
module hazard_ctrl #(
    parameter int regindex = 5,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [regindex-1:0] id_rs1,
    input  logic [regindex-1:0] id_rs2,
    input  logic                id_uses_rs1,
    input  logic                id_uses_rs2,
    input  logic [regindex-1:0] ex_rd,
    input  logic                ex_memread,
    input  logic                br_taken,
    input  logic                mem_req,
    input  logic                mem_ack,
    output logic                pc_en,
    output logic                ifid_en,
    output logic                idex_en,
    output logic                exmem_en,
    output logic                ifid_flush,
    output logic                idex_flush,
    output logic                mem_err,
    output logic [15:0]         stall_cnt,
    output logic                state_o
);

    typedef enum logic {
        RUN   = 1'b0,
        MWAIT = 1'b1
    } state_t;

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_d;
    logic [7:0] wcnt;
    logic [7:0] wcnt_d;
    logic       at_limit;
    logic       hold;
    logic       load_use;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       tmo;

    assign at_limit = (state == MWAIT) && (wcnt == LIMIT);
    assign hold     = mem_req && !mem_ack && !at_limit;
    assign tmo      = at_limit && mem_req && !mem_ack;

    assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    assign load_use = ex_memread && (ex_rd != '0) && (rs1_hit || rs2_hit);

    assign state_o  = (state == MWAIT);

    // Enables and flushes: reset, then memory hold, then branch,
    // then load-use; a branch seen while held waits for the exit cycle.
    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (rst) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (hold) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
        end else if (br_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_comb begin
        state_d = state;
        wcnt_d  = wcnt;
        if (hold) begin
            state_d = MWAIT;
            wcnt_d  = (state == RUN) ? 8'd1 : wcnt + 8'd1;
        end else begin
            state_d = RUN;
            wcnt_d  = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            wcnt  <= 8'd0;
        end else begin
            state <= state_d;
            wcnt  <= wcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_err <= 1'b0;
        end else if (tmo) begin
            mem_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (!pc_en && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: rule-level model checked every cycle
// plus directed vectors with hand-computed literal expectations.
module tb_hazard_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs1 = '0;
    logic [4:0]  id_rs2 = '0;
    logic        id_uses_rs1 = 1'b0;
    logic        id_uses_rs2 = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        ex_memread = 1'b0;
    logic        br_taken = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_ack = 1'b0;
    logic        pc_en;
    logic        ifid_en;
    logic        idex_en;
    logic        exmem_en;
    logic        ifid_flush;
    logic        idex_flush;
    logic        mem_err;
    logic [15:0] stall_cnt;
    logic        state_o;

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(.regindex(5), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_memread(ex_memread),
        .br_taken(br_taken),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(pc_en), .ifid_en(ifid_en),
        .idex_en(idex_en), .exmem_en(exmem_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .mem_err(mem_err), .stall_cnt(stall_cnt),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Model: an access may stall at most TMO-1 consecutive cycles.
    int          m_wait  = 0;
    int unsigned m_stall = 0;
    bit          m_err   = 0;

    always @(negedge clk) begin
        bit hold;
        bit lu;
        bit [3:0] en;
        bit [1:0] fl;
        hold = mem_req && !mem_ack && (m_wait < TMO - 1);
        lu = ex_memread && (ex_rd != 0) &&
             ((id_uses_rs1 && id_rs1 == ex_rd) ||
              (id_uses_rs2 && id_rs2 == ex_rd));
        if (rst)           begin en = 4'b0000; fl = 2'b11; end
        else if (hold)     begin en = 4'b0000; fl = 2'b00; end
        else if (br_taken) begin en = 4'b1111; fl = 2'b11; end
        else if (lu)       begin en = 4'b0011; fl = 2'b01; end
        else               begin en = 4'b1111; fl = 2'b00; end
        chk("m_en", {12'd0, pc_en, ifid_en, idex_en, exmem_en},
            {12'd0, en});
        chk("m_flush", {14'd0, ifid_flush, idex_flush}, {14'd0, fl});
        chk("m_state", {15'd0, state_o}, {15'd0, m_wait != 0});
        chk("m_stall", stall_cnt, m_stall[15:0]);
        chk("m_err", {15'd0, mem_err}, {15'd0, m_err});
        if (rst) begin
            m_wait  = 0;
            m_stall = 0;
            m_err   = 0;
        end else begin
            if (!en[3] && m_stall < 16'hFFFF) m_stall++;
            if (mem_req && !mem_ack && m_wait == TMO - 1) m_err = 1;
            m_wait = hold ? m_wait + 1 : 0;
        end
    end

    task automatic cyc(input logic r, input logic req, input logic ack,
                       input logic br, input logic mr,
                       input logic [4:0] rd, input logic [4:0] s1,
                       input logic [4:0] s2, input logic u1,
                       input logic u2);
        @(posedge clk);
        #1;
        rst = r; mem_req = req; mem_ack = ack; br_taken = br;
        ex_memread = mr; ex_rd = rd; id_rs1 = s1; id_rs2 = s2;
        id_uses_rs1 = u1; id_uses_rs2 = u2;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_pc_en", {15'd0, pc_en}, 16'd0);
        chk("rst_ifid_flush", {15'd0, ifid_flush}, 16'd1);
        chk("rst_stall", stall_cnt, 16'd0);
        chk("rst_state", {15'd0, state_o}, 16'd0);
        idle();
        chk("idle_pc_en", {15'd0, pc_en}, 16'd1);

        cyc(0, 0, 0, 0, 1, 5, 5, 0, 1, 0);
        chk("lu_pc_en", {15'd0, pc_en}, 16'd0);
        chk("lu_ifid_en", {15'd0, ifid_en}, 16'd0);
        chk("lu_idex_en", {15'd0, idex_en}, 16'd1);
        chk("lu_idex_flush", {15'd0, idex_flush}, 16'd1);
        chk("lu_ifid_flush", {15'd0, ifid_flush}, 16'd0);
        idle();
        chk("lu_one_cycle", {15'd0, pc_en}, 16'd1);
        chk("lu_stall", stall_cnt, 16'd1);

        cyc(0, 0, 0, 0, 1, 7, 0, 7, 0, 1);
        chk("lu_rs2_pc_en", {15'd0, pc_en}, 16'd0);
        cyc(0, 0, 0, 0, 1, 5, 5, 0, 0, 0);
        chk("nouse_pc_en", {15'd0, pc_en}, 16'd1);
        chk("nouse_stall", stall_cnt, 16'd2);
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        chk("rd0_pc_en", {15'd0, pc_en}, 16'd1);
        chk("rd0_ifid_en", {15'd0, ifid_en}, 16'd1);

        cyc(0, 0, 0, 1, 1, 5, 5, 0, 1, 0);
        chk("br_flush", {14'd0, ifid_flush, idex_flush}, 16'd3);
        chk("br_en", {12'd0, pc_en, ifid_en, idex_en, exmem_en}, 16'hF);
        idle();
        chk("br_stall", stall_cnt, 16'd2);

        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mw1_state", {15'd0, state_o}, 16'd0);
        chk("mw1_exmem_en", {15'd0, exmem_en}, 16'd0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mw2_state", {15'd0, state_o}, 16'd1);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mw3_pc_en", {15'd0, pc_en}, 16'd0);
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("mw_ack_state", {15'd0, state_o}, 16'd1);
        chk("mw_ack_pc_en", {15'd0, pc_en}, 16'd1);
        idle();
        chk("mw_exit_state", {15'd0, state_o}, 16'd0);
        chk("mw_stall", stall_cnt, 16'd5);

        cyc(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("bw1_flush", {14'd0, ifid_flush, idex_flush}, 16'd0);
        cyc(0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("bw2_flush", {14'd0, ifid_flush, idex_flush}, 16'd0);
        cyc(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        chk("bw_exit_flush", {14'd0, ifid_flush, idex_flush}, 16'd3);
        chk("bw_exit_pc_en", {15'd0, pc_en}, 16'd1);
        idle();
        chk("bw_stall", stall_cnt, 16'd7);

        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            chk("to_hold_pc_en", {15'd0, pc_en}, 16'd0);
        end
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("to_adv_pc_en", {15'd0, pc_en}, 16'd1);
        chk("to_adv_state", {15'd0, state_o}, 16'd1);
        idle();
        chk("to_err", {15'd0, mem_err}, 16'd1);
        chk("to_state", {15'd0, state_o}, 16'd0);
        chk("to_stall", stall_cnt, 16'd10);
        idle();
        idle();
        chk("to_err_sticky", {15'd0, mem_err}, 16'd1);

        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rm_state", {15'd0, state_o}, 16'd1);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rm_pc_en", {15'd0, pc_en}, 16'd0);
        chk("rm_flush", {14'd0, ifid_flush, idex_flush}, 16'd3);
        idle();
        chk("rm_state_after", {15'd0, state_o}, 16'd0);
        chk("rm_stall_after", stall_cnt, 16'd0);
        chk("rm_err_after", {15'd0, mem_err}, 16'd0);

        cyc(0, 0, 0, 0, 1, 3, 0, 3, 0, 1);
        idle();
        chk("post_rst_stall", stall_cnt, 16'd1);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1);
    end

endmodule
